music_player_ctrl_param: RTL and testbench

- Parametrised next-generation song sequencer; sits between the word-addressed song memory and the multi-note player.
- Fetches note words for the selected song over a valid/ready memory request port, with a variable-latency response.
- Hands each note and its duration to the player, then waits for the player to finish.
- Adds duration fields, loop mode, pause, abort and song-region overflow protection.

---
 rtl/music_player_ctrl_param.sv | 134 +++++++++++++
 tb/tb_music_player_ctrl_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_player_ctrl_param.sv
// music_player_ctrl_param: song sequencer fetching note words from memory and feeding the note player
module music_player_ctrl_param #(
    parameter int NOTE_BITS       = 3,
    parameter int DUR_BITS        = 8,
    parameter int SEL_BITS        = 5,
    parameter int SONG_BYTES_LOG2 = 9,
    parameter int ADDR_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_BITS-1:0]  song_sel,
    input  logic                 start_song,
    input  logic                 loop_en,
    input  logic                 pause,
    input  logic                 abort,
    output logic [2:0]           state,
    output logic                 idle,
    output logic [15:0]          note_count,
    output logic [NOTE_BITS-1:0] play_note,
    output logic [DUR_BITS-1:0]  play_dur,
    output logic                 play_load,
    input  logic                 play_done,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    output logic [ADDR_W-1:0]    memreq_addr,
    input  logic                 memresp_val,
    input  logic [31:0]          memresp_data
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_IDLE   = 3'd1,
        S_REQ    = 3'd2,
        S_RESP   = 3'd3,
        S_LOAD   = 3'd4,
        S_WAIT   = 3'd5,
        S_PAUSED = 3'd6
    } state_e;

    state_e               state_q, state_d, go_req;
    logic [ADDR_W-1:0]    addr_q, addr_d, base_sel, base_cur, addr_inc;
    logic [NOTE_BITS-1:0] note_q, note_d;
    logic [DUR_BITS-1:0]  dur_q, dur_d, dur_f;
    logic [15:0]          count_q, count_d;
    logic                 load_q, load_d, loop_q, loop_d, wrap, end_mark;

    // the song base is recovered from the current address since it never leaves its region
    assign base_sel   = ADDR_W'({song_sel, {SONG_BYTES_LOG2{1'b0}}});
    assign base_cur   = {addr_q[ADDR_W-1:SONG_BYTES_LOG2], {SONG_BYTES_LOG2{1'b0}}};
    assign addr_inc   = addr_q + ADDR_W'(4);
    assign wrap       = addr_inc[SONG_BYTES_LOG2-1:0] == '0;
    assign end_mark   = memresp_data == 32'hFFFF_FFFF;
    assign dur_f      = memresp_data[16+DUR_BITS-1:16];
    assign go_req     = pause ? S_PAUSED : S_REQ;
    assign state      = state_q;
    assign idle       = state_q == S_IDLE;
    assign memreq_val = state_q == S_REQ;
    assign memreq_addr = addr_q;
    assign note_count = count_q;
    assign play_note  = note_q;
    assign play_dur   = dur_q;
    assign play_load  = load_q;

    // next-state and datapath updates; abort overrides every transition except out of RESET/illegal
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        dur_d   = dur_q;
        count_d = count_q;
        loop_d  = loop_q;
        load_d  = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_IDLE;
            S_IDLE:   if (start_song) begin
                addr_d  = base_sel;
                count_d = '0;
                loop_d  = loop_en;
                state_d = go_req;
            end
            S_REQ:    state_d = memreq_rdy ? S_RESP : (pause ? S_PAUSED : S_REQ);
            S_PAUSED: state_d = pause ? S_PAUSED : S_REQ;
            S_RESP:   if (memresp_val) begin
                if (end_mark) begin
                    addr_d  = base_cur;
                    state_d = loop_q ? go_req : S_IDLE;
                end else begin
                    note_d  = memresp_data[NOTE_BITS-1:0];
                    dur_d   = (dur_f == '0) ? DUR_BITS'(1) : dur_f;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                state_d = S_WAIT;
            end
            S_WAIT:   if (play_done) begin
                addr_d  = wrap ? base_cur : addr_inc;
                state_d = (wrap && !loop_q) ? S_IDLE : go_req;
            end
            default:  state_d = S_RESET;
        endcase
        if (abort && state_q != S_RESET && state_d != S_RESET) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            note_d  = note_q;
            dur_d   = dur_q;
            loop_d  = loop_q;
            load_d  = 1'b0;
            if (state_q != S_LOAD) count_d = count_q;
        end
    end

    // state and registered outputs, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
            addr_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            count_q <= '0;
            loop_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            count_q <= count_d;
            loop_q  <= loop_d;
            load_q  <= load_d;
        end
    end
endmodule

// File: tb/tb_music_player_ctrl_param.sv
// tb_music_player_ctrl_param: directed bench with a memory responder and a note player model
module tb_music_player_ctrl_param;
    logic        clk = 1'b0, rst = 1'b0;
    logic [4:0]  song_sel = '0;
    logic        start_song = 1'b0, loop_en = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [2:0]  state;
    logic        idle, play_load, play_done = 1'b0;
    logic [15:0] note_count;
    logic [2:0]  play_note;
    logic [7:0]  play_dur;
    logic        memreq_val, memreq_rdy = 1'b1, memresp_val = 1'b0;
    logic [15:0] memreq_addr;
    logic [31:0] memresp_data = '0;

    music_player_ctrl_param dut (
        .clk(clk), .rst(rst), .song_sel(song_sel), .start_song(start_song),
        .loop_en(loop_en), .pause(pause), .abort(abort), .state(state), .idle(idle),
        .note_count(note_count), .play_note(play_note), .play_dur(play_dur),
        .play_load(play_load), .play_done(play_done), .memreq_val(memreq_val),
        .memreq_rdy(memreq_rdy), .memreq_addr(memreq_addr), .memresp_val(memresp_val),
        .memresp_data(memresp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  note;
        logic [7:0]  dur;
    } vec_t;

    logic [31:0] mem [0:1023];
    logic [15:0] req_q[$];
    logic [2:0]  ldn_q[$];
    logic [7:0]  ldd_q[$];
    int total = 0, bad = 0;

    // memory: record each accepted request and answer it two cycles later
    initial begin
        logic [15:0] a;
        forever begin
            @(negedge clk);
            if (memreq_val && memreq_rdy) begin
                a = memreq_addr;
                req_q.push_back(a);
                repeat (2) @(posedge clk);
                #1 memresp_val = 1'b1;
                memresp_data = mem[a[11:2]];
                @(posedge clk);
                #1 memresp_val = 1'b0;
            end
        end
    end

    // player: capture each load and report completion a few cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (play_load) begin
                ldn_q.push_back(play_note);
                ldd_q.push_back(play_dur);
                repeat (2) @(posedge clk);
                #1 play_done = 1'b1;
                @(posedge clk);
                #1 play_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string name);
        int n = 0;
        while (state !== s && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state), 32'(s));
    endtask

    task automatic start(input logic [4:0] sel, input logic lp);
        @(posedge clk);
        #1 song_sel = sel;
        loop_en = lp;
        start_song = 1'b1;
        @(posedge clk);
        #1 start_song = 1'b0;
    endtask

    task automatic clear_logs();
        req_q.delete();
        ldn_q.delete();
        ldd_q.delete();
    endtask

    initial begin
        vec_t vecs[6];
        int n;
        vecs[0] = '{32'h0000_0004, 3'd4, 8'd1};
        vecs[1] = '{32'h0005_0002, 3'd2, 8'd5};
        vecs[2] = '{32'h00FF_0007, 3'd7, 8'hFF};
        vecs[3] = '{32'h1234_0005, 3'd5, 8'h34};
        vecs[4] = '{32'h0001_FFF8, 3'd0, 8'd1};
        vecs[5] = '{32'hFFFE_FFFF, 3'd7, 8'hFE};
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;

        // reset values
        @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_idle", 32'(idle), 0);
        check("rst_val", 32'(memreq_val), 0);
        check("rst_load", 32'(play_load), 0);
        check("rst_count", 32'(note_count), 0);
        check("rst_note", 32'(play_note), 0);
        check("rst_dur", 32'(play_dur), 0);
        check("rst_addr", 32'(memreq_addr), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check("post_rst_state", 32'(state), 1);
        check("post_rst_idle", 32'(idle), 1);

        // basic song 3 playback
        mem[10'h180] = 32'h0005_0002;
        mem[10'h181] = 32'h0003_0007;
        clear_logs();
        start(5'd3, 1'b0);
        check("s1_first_val", 32'(memreq_val), 1);
        check("s1_first_addr", 32'(memreq_addr), 32'h600);
        wait_state(3'd1, 200, "s1_end_idle");
        check("s1_nreq", 32'(req_q.size()), 3);
        check("s1_addr0", 32'(req_q[0]), 32'h600);
        check("s1_addr1", 32'(req_q[1]), 32'h604);
        check("s1_addr2", 32'(req_q[2]), 32'h608);
        check("s1_nload", 32'(ldn_q.size()), 2);
        check("s1_note0", 32'(ldn_q[0]), 2);
        check("s1_dur0", 32'(ldd_q[0]), 5);
        check("s1_note1", 32'(ldn_q[1]), 7);
        check("s1_dur1", 32'(ldd_q[1]), 3);
        check("s1_count", 32'(note_count), 2);

        // memory stalls the first request
        mem[10'h080] = 32'h0002_0001;
        clear_logs();
        memreq_rdy = 1'b0;
        start(5'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s2_hold_val", 32'(memreq_val), 1);
            check("s2_hold_addr", 32'(memreq_addr), 32'h200);
        end
        @(posedge clk);
        #1 memreq_rdy = 1'b1;
        wait_state(3'd1, 200, "s2_end_idle");
        check("s2_nreq", 32'(req_q.size()), 2);
        check("s2_addr0", 32'(req_q[0]), 32'h200);
        check("s2_addr1", 32'(req_q[1]), 32'h204);

        // loop mode on song 0, then abort
        mem[0] = 32'h0001_0001;
        mem[1] = 32'hFFFF_FFFF;
        clear_logs();
        start(5'd0, 1'b1);
        n = 0;
        while ((req_q.size() < 3 || ldn_q.size() < 2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("s3_reached", 32'(n < 300), 1);
        check("s3_addr0", 32'(req_q[0]), 0);
        check("s3_addr1", 32'(req_q[1]), 4);
        check("s3_addr2", 32'(req_q[2]), 0);
        check("s3_note1", 32'(ldn_q[1]), 1);
        check("s3_dur1", 32'(ldd_q[1]), 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("s3_abort_state", 32'(state), 1);
        check("s3_abort_val", 32'(memreq_val), 0);
        repeat (8) @(posedge clk);
        #1 check("s3_abort_stay", 32'(state), 1);

        // abort together with start in IDLE
        clear_logs();
        @(posedge clk);
        #1 start_song = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start_song = 1'b0;
        abort = 1'b0;
        check("s3b_state", 32'(state), 1);
        check("s3b_val", 32'(memreq_val), 0);

        // duration and note decoding table
        for (int i = 0; i < 6; i++) begin
            mem[10'h100] = vecs[i].word;
            mem[10'h101] = 32'hFFFF_FFFF;
            clear_logs();
            start(5'd2, 1'b0);
            wait_state(3'd1, 200, "tv_idle");
            check("tv_nload", 32'(ldn_q.size()), 1);
            check("tv_note", 32'(ldn_q[0]), 32'(vecs[i].note));
            check("tv_dur", 32'(ldd_q[0]), 32'(vecs[i].dur));
            check("tv_count", 32'(note_count), 1);
        end

        // pause during a note
        mem[10'h200] = 32'h0002_0003;
        mem[10'h201] = 32'h0002_0004;
        mem[10'h202] = 32'hFFFF_FFFF;
        clear_logs();
        start(5'd4, 1'b0);
        wait_state(3'd5, 50, "s5_wait");
        pause = 1'b1;
        n = req_q.size();
        wait_state(3'd6, 50, "s5_paused");
        check("s5_one_load", 32'(ldn_q.size()), 1);
        repeat (3) @(negedge clk);
        check("s5_no_req", 32'(req_q.size()), 32'(n));
        check("s5_val_low", 32'(memreq_val), 0);
        @(posedge clk);
        #1 pause = 1'b0;
        @(posedge clk);
        #1 check("s5_resume_val", 32'(memreq_val), 1);
        check("s5_resume_addr", 32'(memreq_addr), 32'h804);
        wait_state(3'd1, 200, "s5_idle");
        check("s5_count", 32'(note_count), 2);

        // 128-note region without an end marker
        for (int i = 0; i < 128; i++) mem[10'h280 + i] = 32'h0001_0001;
        mem[10'h300] = 32'h0001_0006;
        clear_logs();
        start(5'd5, 1'b0);
        wait_state(3'd1, 4000, "s6_idle");
        check("s6_count", 32'(note_count), 128);
        check("s6_nreq", 32'(req_q.size()), 128);
        check("s6_last_addr", 32'(req_q[127]), 32'hBFC);
        check("s6_nload", 32'(ldn_q.size()), 128);
        check("s6_val", 32'(memreq_val), 0);

        // asynchronous reset in the middle of a response wait
        clear_logs();
        start(5'd3, 1'b0);
        n = 0;
        while (ldn_q.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        wait_state(3'd3, 50, "s7_resp");
        check("s7_count_pre", 32'(note_count), 1);
        #2 rst = 1'b0;
        #1 check("s7_state", 32'(state), 0);
        check("s7_idle", 32'(idle), 0);
        check("s7_val", 32'(memreq_val), 0);
        check("s7_addr", 32'(memreq_addr), 0);
        check("s7_count", 32'(note_count), 0);
        check("s7_note", 32'(play_note), 0);
        check("s7_dur", 32'(play_dur), 0);
        check("s7_load", 32'(play_load), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
